// File: rtl/execute_cc_stage.sv
// execute_cc_stage: Y86-64 execute control, condition codes and E/M pipeline register
module execute_cc_stage #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   e_stat,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] e_valA,
  input  logic [W-1:0] e_valB,
  input  logic [W-1:0] e_valC,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   e_dstM,
  input  logic         cc_en,
  input  logic         stall,
  input  logic         bubble,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_fn,
  input  logic [W-1:0] alu_vale,
  input  logic         alu_car,
  output logic         e_cnd,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         cc_cf,
  output logic [2:0]   m_stat,
  output logic [3:0]   m_icode,
  output logic         m_cnd,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic [3:0]   m_dstM
);
  localparam logic [3:0] I_NOP = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4,
                         I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                         I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
  localparam logic [W-1:0] STEP = W'(STACK_STEP);
  logic         w_sa, w_sb, w_sr, w_of, w_cf, w_lt, w_cc_we;
  logic [3:0]   w_dstE;
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = 4'h0;
    case (e_icode)
      I_OPQ: begin
        alu_a  = e_valB;
        alu_b  = e_valA;
        alu_fn = (e_ifun > 4'h3) ? 4'h0 : e_ifun;
      end
      I_CMOV:           alu_a = e_valA;
      I_IRMOV:          alu_a = e_valC;
      I_RMMOV, I_MRMOV: begin
        alu_a = e_valB;
        alu_b = e_valC;
      end
      I_CALL, I_PUSH: begin
        alu_a = e_valB;
        alu_b = -STEP;
      end
      I_RET, I_POP: begin
        alu_a = e_valB;
        alu_b = STEP;
      end
      default: ;
    endcase
  end
  // overflow is judged against the operands actually presented to the ALU
  assign w_sa = alu_a[W-1];
  assign w_sb = alu_b[W-1];
  assign w_sr = alu_vale[W-1];
  assign w_of = (alu_fn == 4'h0) ? (w_sa == w_sb) && (w_sr != w_sa) :
                (alu_fn == 4'h1) ? (w_sa != w_sb) && (w_sr != w_sa) : 1'b0;
  assign w_cf = (alu_fn < 4'h2) ? alu_car : 1'b0;
  assign w_cc_we = (e_icode == I_OPQ) && cc_en && !stall;
  assign w_lt = cc_sf ^ cc_of;
  always_comb begin
    e_cnd = 1'b0;
    if (e_icode == I_CMOV || e_icode == I_JXX)
      case (e_ifun)
        4'h0:    e_cnd = 1'b1;
        4'h1:    e_cnd = w_lt | cc_zf;
        4'h2:    e_cnd = w_lt;
        4'h3:    e_cnd = cc_zf;
        4'h4:    e_cnd = !cc_zf;
        4'h5:    e_cnd = !w_lt;
        4'h6:    e_cnd = !w_lt && !cc_zf;
        default: e_cnd = 1'b0;
      endcase
  end
  assign w_dstE = (e_icode == I_CMOV && !e_cnd) ? 4'hF : e_dstE;
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
      cc_cf <= 1'b0;
    end else if (w_cc_we) begin
      cc_zf <= (alu_vale == '0);
      cc_sf <= w_sr;
      cc_of <= w_of;
      cc_cf <= w_cf;
    end
  end
  // bubble outranks stall so a flushed slot never holds a stale instruction
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      m_stat  <= 3'd1;
      m_icode <= I_NOP;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= 4'hF;
      m_dstM  <= 4'hF;
    end else if (!stall) begin
      m_stat  <= e_stat;
      m_icode <= e_icode;
      m_cnd   <= e_cnd;
      m_valE  <= alu_vale;
      m_valA  <= e_valA;
      m_dstE  <= w_dstE;
      m_dstM  <= e_dstM;
    end
  end
endmodule

// File: tb/tb_execute_cc_stage.sv
// tb_execute_cc_stage: directed checks of operand select, CC, conditions and E/M register
module tb_execute_cc_stage;
  localparam int W = 64;
  logic         clk, rst, cc_en, stall, bubble, alu_car;
  logic [2:0]   e_stat;
  logic [3:0]   e_icode, e_ifun, e_dstE, e_dstM, alu_fn;
  logic [W-1:0] e_valA, e_valB, e_valC, alu_a, alu_b, alu_vale;
  logic         e_cnd, cc_zf, cc_sf, cc_of, cc_cf, m_cnd;
  logic [2:0]   m_stat;
  logic [3:0]   m_icode, m_dstE, m_dstM;
  logic [W-1:0] m_valE, m_valA;
  int n_chk = 0, n_fail = 0;

  execute_cc_stage #(.W(W), .STACK_STEP(8)) dut (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .cc_en(cc_en), .stall(stall), .bubble(bubble), .alu_a(alu_a), .alu_b(alu_b),
    .alu_fn(alu_fn), .alu_vale(alu_vale), .alu_car(alu_car), .e_cnd(e_cnd),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .cc_cf(cc_cf), .m_stat(m_stat),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valE(m_valE), .m_valA(m_valA),
    .m_dstE(m_dstE), .m_dstM(m_dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] vc, input logic [3:0] de,
                         input logic [3:0] dm, input logic [W-1:0] res, input logic car);
    e_stat = 3'd1; e_icode = ic; e_ifun = fn; e_valA = va; e_valB = vb; e_valC = vc;
    e_dstE = de; e_dstM = dm; alu_vale = res; alu_car = car;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cc_en = 1'b1; stall = 1'b0; bubble = 1'b0;
    present(4'h6, 4'h1, 64'h0, 64'h1, 64'h0, 4'h3, 4'h4, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    rst = 1'b0;
    present(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 64'h0, 1'b0);
    n_chk++; if (m_icode !== 4'h1) begin n_fail++; $display("FAIL rst_icode got %h want 1", m_icode); end
    n_chk++; if (m_stat !== 3'd1) begin n_fail++; $display("FAIL rst_stat got %h want 1", m_stat); end
    n_chk++; if (m_dstE !== 4'hF || m_dstM !== 4'hF) begin n_fail++; $display("FAIL rst_dst got %h/%h want f/f", m_dstE, m_dstM); end
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b1000) begin n_fail++; $display("FAIL rst_cc got %b want 1000", {cc_zf, cc_sf, cc_of, cc_cf}); end
    n_chk++; if (e_cnd !== 1'b0) begin n_fail++; $display("FAIL rst_cnd got %b want 0", e_cnd); end
  endtask

  task automatic test_opq_sub();
    present(4'h6, 4'h1, 64'd5, 64'd3, 64'h0, 4'h2, 4'hF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    n_chk++; if (alu_a !== 64'd3 || alu_b !== 64'd5 || alu_fn !== 4'h1) begin n_fail++; $display("FAIL sub_ops got %h %h %h want 3 5 1", alu_a, alu_b, alu_fn); end
    tick();
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b0101) begin n_fail++; $display("FAIL sub_cc got %b want 0101", {cc_zf, cc_sf, cc_of, cc_cf}); end
    n_chk++; if (m_valE !== 64'hFFFF_FFFF_FFFF_FFFE || m_icode !== 4'h6 || m_dstE !== 4'h2) begin n_fail++; $display("FAIL sub_em got %h %h %h want fffffffffffffffe 6 2", m_valE, m_icode, m_dstE); end
    present(4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF, 64'h0, 1'b0);
    n_chk++; if (e_cnd !== 1'b1) begin n_fail++; $display("FAIL jl got %b want 1", e_cnd); end
    present(4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF, 64'h0, 1'b0);
    n_chk++; if (e_cnd !== 1'b0) begin n_fail++; $display("FAIL je got %b want 0", e_cnd); end
    present(4'h6, 4'h7, 64'd1, 64'd2, 64'h0, 4'hF, 4'hF, 64'h0, 1'b0);
    cc_en = 1'b0;
    #1;
    n_chk++; if (alu_fn !== 4'h0) begin n_fail++; $display("FAIL opq_badfn got %h want 0", alu_fn); end
    present(4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h5, 4'hF, 64'h1234, 1'b0);
    n_chk++; if (alu_a !== 64'h1234 || alu_b !== 64'h0 || alu_fn !== 4'h0) begin n_fail++; $display("FAIL irmov_ops got %h %h %h want 1234 0 0", alu_a, alu_b, alu_fn); end
    present(4'h5, 4'h0, 64'h0, 64'h200, 64'h18, 4'hF, 4'h6, 64'h218, 1'b0);
    n_chk++; if (alu_a !== 64'h200 || alu_b !== 64'h18) begin n_fail++; $display("FAIL mrmov_ops got %h %h want 200 18", alu_a, alu_b); end
    cc_en = 1'b1;
  endtask

  task automatic test_opq_add_of();
    present(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h1, 4'hF, 64'h8000_0000_0000_0000, 1'b0);
    tick();
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b0110) begin n_fail++; $display("FAIL add_of_cc got %b want 0110", {cc_zf, cc_sf, cc_of, cc_cf}); end
    cc_en = 1'b0;
    present(4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'h1, 4'hF, 64'h0, 1'b1);
    tick();
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b0110) begin n_fail++; $display("FAIL cc_en_hold got %b want 0110", {cc_zf, cc_sf, cc_of, cc_cf}); end
    n_chk++; if (m_valE !== 64'h0) begin n_fail++; $display("FAIL cc_en_em got %h want 0", m_valE); end
    cc_en = 1'b1;
  endtask

  task automatic test_cmov();
    present(4'h6, 4'h0, 64'd3, 64'd2, 64'h0, 4'h1, 4'hF, 64'd5, 1'b0);
    tick();
    present(4'h2, 4'h1, 64'h55, 64'h0, 64'h0, 4'h3, 4'hF, 64'h55, 1'b0);
    n_chk++; if (alu_a !== 64'h55 || alu_b !== 64'h0 || e_cnd !== 1'b0) begin n_fail++; $display("FAIL cmov_ops got %h %h %b want 55 0 0", alu_a, alu_b, e_cnd); end
    tick();
    n_chk++; if (m_dstE !== 4'hF || m_valE !== 64'h55 || m_cnd !== 1'b0) begin n_fail++; $display("FAIL cmov_nt got %h %h %b want f 55 0", m_dstE, m_valE, m_cnd); end
    present(4'h6, 4'h3, 64'd7, 64'd7, 64'h0, 4'h1, 4'hF, 64'd0, 1'b0);
    tick();
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b1000) begin n_fail++; $display("FAIL xor_cc got %b want 1000", {cc_zf, cc_sf, cc_of, cc_cf}); end
    present(4'h2, 4'h1, 64'h55, 64'h0, 64'h0, 4'h3, 4'hF, 64'h55, 1'b0);
    tick();
    n_chk++; if (m_dstE !== 4'h3 || m_cnd !== 1'b1) begin n_fail++; $display("FAIL cmov_t got %h %b want 3 1", m_dstE, m_cnd); end
  endtask

  task automatic test_push_pop();
    present(4'hA, 4'h0, 64'hABCD, 64'h100, 64'h0, 4'h4, 4'hF, 64'hF8, 1'b1);
    n_chk++; if (alu_a !== 64'h100 || alu_b !== 64'hFFFF_FFFF_FFFF_FFF8 || alu_fn !== 4'h0) begin n_fail++; $display("FAIL push_ops got %h %h %h want 100 fffffffffffffff8 0", alu_a, alu_b, alu_fn); end
    tick();
    n_chk++; if (m_valE !== 64'hF8 || m_valA !== 64'hABCD || m_icode !== 4'hA) begin n_fail++; $display("FAIL push_em got %h %h %h want f8 abcd a", m_valE, m_valA, m_icode); end
    present(4'hB, 4'h0, 64'h100, 64'h100, 64'h0, 4'h4, 4'h7, 64'h108, 1'b0);
    n_chk++; if (alu_b !== 64'h8) begin n_fail++; $display("FAIL pop_ops got %h want 8", alu_b); end
    tick();
    n_chk++; if (m_valE !== 64'h108 || m_dstM !== 4'h7 || m_dstE !== 4'h4) begin n_fail++; $display("FAIL pop_em got %h %h %h want 108 7 4", m_valE, m_dstM, m_dstE); end
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b1000) begin n_fail++; $display("FAIL pop_cc got %b want 1000", {cc_zf, cc_sf, cc_of, cc_cf}); end
  endtask

  task automatic test_stall_bubble();
    present(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h1, 4'hF, 64'h8000_0000_0000_0000, 1'b0);
    stall = 1'b1;
    tick();
    n_chk++; if (m_icode !== 4'hB || m_valE !== 64'h108 || m_dstM !== 4'h7) begin n_fail++; $display("FAIL stall_em got %h %h %h want b 108 7", m_icode, m_valE, m_dstM); end
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b1000) begin n_fail++; $display("FAIL stall_cc got %b want 1000", {cc_zf, cc_sf, cc_of, cc_cf}); end
    bubble = 1'b1;
    tick();
    n_chk++; if (m_icode !== 4'h1 || m_stat !== 3'd1 || m_valE !== 64'h0 || m_valA !== 64'h0 || m_dstE !== 4'hF || m_dstM !== 4'hF || m_cnd !== 1'b0) begin n_fail++; $display("FAIL bubble_em got %h %h %h %h %h %h %b want 1 1 0 0 f f 0", m_icode, m_stat, m_valE, m_valA, m_dstE, m_dstM, m_cnd); end
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b1000) begin n_fail++; $display("FAIL bubble_cc got %b want 1000", {cc_zf, cc_sf, cc_of, cc_cf}); end
    stall = 1'b0; bubble = 1'b0;
    tick();
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b0110 || m_icode !== 4'h6) begin n_fail++; $display("FAIL resume got %b %h want 0110 6", {cc_zf, cc_sf, cc_of, cc_cf}, m_icode); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({cc_zf, cc_sf, cc_of, cc_cf} !== 4'b1000 || m_icode !== 4'h1 || m_valE !== 64'h0) begin n_fail++; $display("FAIL midrst got %b %h %h want 1000 1 0", {cc_zf, cc_sf, cc_of, cc_cf}, m_icode, m_valE); end
  endtask

  initial begin
    test_reset();
    test_opq_sub();
    test_opq_add_of();
    test_cmov();
    test_push_pop();
    test_stall_bubble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_cc_stage.md
Name: execute_cc_stage

Overview:
- Y86-64 execute-stage control wrapped around the 64-bit ALU (fn 0 add, 1 sub A−B, 2 and, 3 xor).
- Selects the ALU operands and function from decoded E-stage fields, and consumes the ALU result and carry.
- Holds the condition-code register and evaluates jXX/cmovXX conditions.
- Captures results into the E/M pipeline register that feeds the memory stage.

Parameters:
W, 64, datapath width
STACK_STEP, 8, byte adjustment applied to %rsp for call/push/ret/pop

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
e_stat  in  3  E-stage status (1=AOK)
e_icode  in  4  instruction code
e_ifun  in  4  function code
e_valA  in  W  operand A from decode
e_valB  in  W  operand B from decode
e_valC  in  W  immediate/displacement
e_dstE  in  4  E destination register (0xF=none)
e_dstM  in  4  M destination register
cc_en  in  1  permits CC update (controller drops it on exceptions downstream)
stall  in  1  hold E/M register and CC
bubble  in  1  load nop into E/M register
alu_a  out  W  to ALU_A
alu_b  out  W  to ALU_B
alu_fn  out  4  to ALU_fn
alu_vale  in  W  from ALU valE
alu_car  in  1  from ALU carry
e_cnd  out  1  combinational condition result for the current E instruction
cc_zf, cc_sf, cc_of, cc_cf  out  1 each  condition-code register
m_stat  out  3  registered stat
m_icode  out  4  registered icode
m_cnd  out  1  registered cnd
m_valE  out  W  registered ALU result
m_valA  out  W  registered valA (store data / return address)
m_dstE  out  4  registered dstE (cnd-gated)
m_dstM  out  4  registered dstM

Behaviour:
- Icodes: 0 halt, 1 nop, 2 rrmov/cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, A push, B pop.
- Operand selection is combinational, same cycle:
  - OPq: alu_a=valB, alu_b=valA, alu_fn=ifun, so sub yields valB−valA.
  - cmov: alu_a=valA, alu_b=0.
  - irmov: alu_a=valC, alu_b=0.
  - rmmov/mrmov: alu_a=valB, alu_b=valC.
  - call/push: alu_a=valB, alu_b=−STACK_STEP (two's complement).
  - ret/pop: alu_a=valB, alu_b=+STACK_STEP.
  - All non-OPq and all other icodes: alu_fn=0. Other icodes drive alu_a=alu_b=0.
- OPq with ifun>3 is treated as ifun 0 for alu_fn.
- CC next values:
  - ZF = (alu_vale==0); SF = alu_vale[W−1].
  - OF for add: a,b same sign and result sign differs from a.
  - OF for sub: a,b signs differ and result sign differs from a.
  - OF for and/xor: 0.
  - CF = alu_car for add/sub, 0 for and/xor.
- CC update: at the clock edge when e_icode==6 && cc_en && !stall && !rst; otherwise CC holds. Reset value: ZF=1, SF=0, OF=0, CF=0.
- e_cnd is evaluated from the current (pre-update) CC, for icode 2 or 7 only; otherwise 0.
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun >6: 0.
- E/M register, one-cycle latency, priority rst > bubble > stall > load:
  - Load: m_* takes E values; m_valE=alu_vale; m_cnd=e_cnd.
  - m_dstE=0xF when icode==2 && !e_cnd, else e_dstE.
  - Bubble and reset both load a nop: stat=1, icode=1, cnd=0, valE=0, valA=0, dstE=0xF, dstM=0xF.
  - Stall holds every m_* output.
- Simultaneous stall and bubble: bubble wins for E/M. CC still holds, because stall blocks CC.
- rst mid-sequence: the next edge yields the nop E/M state and the reset CC regardless of other inputs.
- The block is entirely flop plus combinational logic; there is no internal state beyond the CC and E/M registers.

Test Plan:
1. Reset: rst=1 for one edge → m_icode=1, m_dstE=0xF, m_dstM=0xF, ZF=1, SF=0, OF=0, CF=0, e_cnd=0.
2. OPq sub with valA=5, valB=3 → alu_a=3, alu_b=5, alu_fn=1. With the ALU returning 0xFFFF…FFFE → next edge SF=1, ZF=0, OF=0, m_valE=−2. A following jXX ifun 2 (l) gives e_cnd=1; ifun 3 (e) gives e_cnd=0.
3. OPq add of 0x7FFF…FFFF and 1 → OF=1, SF=1, ZF=0. Repeat with cc_en=0 → CC unchanged.
4. cmovle with ZF=0, SF=0, OF=0 → e_cnd=0, m_dstE=0xF, m_valE=valA. Set ZF=1 → m_dstE=e_dstE.
5. pushq with valB=0x100 → alu_b=−8, m_valE=0xF8. popq with valB=0x100 → m_valE=0x108.
6. stall=1 while OPq is presented → m_* and CC are unchanged. stall=1 with bubble=1 → m_* becomes a nop and CC is unchanged.
